// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing the system_bus host port among NUM_HOST requesters.
// Optional busy-timeout completion enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_host_arbiter #(
   parameter int NUM_HOST       = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [NUM_HOST*32-1:0] host_rw_address_i,
   output logic [NUM_HOST*32-1:0] host_read_data_o,
   input  logic [NUM_HOST-1:0]    host_read_request_i,
   output logic [NUM_HOST-1:0]    host_read_response_o,
   input  logic [NUM_HOST*32-1:0] host_write_data_i,
   input  logic [NUM_HOST*4-1:0]  host_write_strobe_i,
   input  logic [NUM_HOST-1:0]    host_write_request_i,
   output logic [NUM_HOST-1:0]    host_write_response_o,
   output logic [31:0]            bus_rw_address_o,
   input  logic [31:0]            bus_read_data_i,
   output logic                   bus_read_request_o,
   input  logic                   bus_read_response_i,
   output logic [31:0]            bus_write_data_o,
   output logic [3:0]             bus_write_strobe_o,
   output logic                   bus_write_request_o,
   input  logic                   bus_write_response_i,
   output logic [NUM_HOST-1:0]    grant_o
);

   localparam int IW = (NUM_HOST > 1) ? $clog2(NUM_HOST) : 1;

   if (NUM_HOST < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("bus_host_arbiter: NUM_HOST must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state;
   logic [IW-1:0]       rr;
   logic [IW-1:0]       owner;
   logic [NUM_HOST-1:0] grant;
   logic                rd_req;
   logic                wr_req;
   logic [31:0]         addr;
   logic [31:0]         wdata;
   logic [3:0]          strobe;

   logic [NUM_HOST-1:0] any_req;
   logic                found;
   logic [IW-1:0]       pick;
   int                  idx;
   logic                bus_done;
   logic                timeout;
   logic                done;

   assign any_req  = host_read_request_i | host_write_request_i;
   assign bus_done = (rd_req & bus_read_response_i) | (wr_req & bus_write_response_i);
   assign done     = bus_done | timeout;

`ifdef BUS_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] count;
   assign timeout = (state == BUSY) && (count == CW'(TIMEOUT_CYCLES)) && !bus_done;
`else
   assign timeout = 1'b0;
`endif

   // First requester after the last winner, wrapping modulo NUM_HOST.
   always_comb begin
      found = 1'b0;
      pick  = rr;
      idx   = 0;
      for (int k = 1; k <= NUM_HOST; k++) begin
         idx = (int'(rr) + k) % NUM_HOST;
         if (!found && any_req[idx]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         rr     <= IW'(NUM_HOST - 1);
         owner  <= '0;
         grant  <= '0;
         rd_req <= 1'b0;
         wr_req <= 1'b0;
         addr   <= '0;
         wdata  <= '0;
         strobe <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
         count  <= '0;
`endif
      end else if (state == IDLE) begin
         if (found) begin
            state  <= BUSY;
            owner  <= pick;
            grant  <= NUM_HOST'(1) << pick;
            // A simultaneous read+write from one host is served as the write.
            wr_req <= host_write_request_i[pick];
            rd_req <= ~host_write_request_i[pick];
            addr   <= host_rw_address_i[32*pick +: 32];
            wdata  <= host_write_data_i[32*pick +: 32];
            strobe <= host_write_strobe_i[4*pick +: 4];
`ifdef BUS_ARBITER_TIMEOUT_EN
            count  <= '0;
`endif
         end
      end else begin
         if (done) begin
            state  <= IDLE;
            rr     <= owner;
            grant  <= '0;
            rd_req <= 1'b0;
            wr_req <= 1'b0;
         end
`ifdef BUS_ARBITER_TIMEOUT_EN
         else begin
            count <= count + 1'b1;
         end
`endif
      end
   end

   assign bus_rw_address_o    = addr;
   assign bus_write_data_o    = wdata;
   assign bus_write_strobe_o  = strobe;
   assign bus_read_request_o  = rd_req;
   assign bus_write_request_o = wr_req;
   assign grant_o             = grant;

   // Responses reach only the granted host, in the same cycle as the bus response.
   always_comb begin
      host_read_response_o  = '0;
      host_write_response_o = '0;
      host_read_data_o      = '0;
      for (int h = 0; h < NUM_HOST; h++) begin
         if (grant[h]) begin
            host_read_response_o[h]    = rd_req & (bus_read_response_i | timeout);
            host_write_response_o[h]   = wr_req & (bus_write_response_i | timeout);
            host_read_data_o[32*h +: 32] = timeout ? 32'h0000_0000 : bus_read_data_i;
         end
      end
   end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Bench for bus_host_arbiter: transaction-level ownership model plus directed scenarios.
// Timeout scenario expectations follow BUS_ARBITER_TIMEOUT_EN when it is defined.
module tb_bus_host_arbiter;

   localparam int N  = 2;
   localparam int TO = 4;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic [N*32-1:0] host_rw_address_i = '0;
   logic [N*32-1:0] host_read_data_o;
   logic [N-1:0]    host_read_request_i = '0;
   logic [N-1:0]    host_read_response_o;
   logic [N*32-1:0] host_write_data_i = '0;
   logic [N*4-1:0]  host_write_strobe_i = '0;
   logic [N-1:0]    host_write_request_i = '0;
   logic [N-1:0]    host_write_response_o;
   logic [31:0]     bus_rw_address_o;
   logic [31:0]     bus_read_data_i = '0;
   logic            bus_read_request_o;
   logic            bus_read_response_i = 1'b0;
   logic [31:0]     bus_write_data_o;
   logic [3:0]      bus_write_strobe_o;
   logic            bus_write_request_o;
   logic            bus_write_response_i = 1'b0;
   logic [N-1:0]    grant_o;

   bus_host_arbiter #(.NUM_HOST(N), .TIMEOUT_CYCLES(TO)) dut (
      .clock                 (clock),
      .reset_n               (reset_n),
      .host_rw_address_i     (host_rw_address_i),
      .host_read_data_o      (host_read_data_o),
      .host_read_request_i   (host_read_request_i),
      .host_read_response_o  (host_read_response_o),
      .host_write_data_i     (host_write_data_i),
      .host_write_strobe_i   (host_write_strobe_i),
      .host_write_request_i  (host_write_request_i),
      .host_write_response_o (host_write_response_o),
      .bus_rw_address_o      (bus_rw_address_o),
      .bus_read_data_i       (bus_read_data_i),
      .bus_read_request_o    (bus_read_request_o),
      .bus_read_response_i   (bus_read_response_i),
      .bus_write_data_o      (bus_write_data_o),
      .bus_write_strobe_o    (bus_write_strobe_o),
      .bus_write_request_o   (bus_write_request_o),
      .bus_write_response_i  (bus_write_response_i),
      .grant_o               (grant_o)
   );

   always #5 clock = ~clock;

   int          errors = 0;
   int          checks = 0;
   // Reference model: who owns the bus, what it asked for, how long until memory answers.
   bit          m_busy = 1'b0;
   int          m_owner = 0;
   int          m_rr = N - 1;
   int          m_lat = 0;
   int          m_cnt = 0;
   bit          m_wr = 1'b0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_data = '0;
   logic [3:0]  m_strb = '0;
   bit          mute = 1'b0;
   int          fixed_lat = -1;
   bit          fixed_rdata_en = 1'b0;
   logic [31:0] fixed_rdata = '0;
   int          done_host = -1;
   bit          just_done [N];
   logic [31:0] got_q [$];
   int          base;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_host(input int h, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
      host_read_request_i[h]         = rd;
      host_write_request_i[h]        = wr;
      host_rw_address_i[32*h +: 32]  = a;
      host_write_data_i[32*h +: 32]  = d;
      host_write_strobe_i[4*h +: 4]  = s;
   endtask

   function automatic bit any_req();
      return |(host_read_request_i | host_write_request_i);
   endfunction

   // One clock cycle: drive memory side, check outputs, advance the model, apply host drops.
   task automatic tick();
      bit          fire;
      bit          tmo;
      bit          found;
      logic [N-1:0] req;
      fire = 1'b0;
      tmo  = 1'b0;
      bus_read_response_i  = 1'b0;
      bus_write_response_i = 1'b0;
      bus_read_data_i = fixed_rdata_en ? fixed_rdata : $urandom;
      if (m_busy) begin
         if (!mute && m_lat == 0) begin
            fire = 1'b1;
            if (m_wr) bus_write_response_i = 1'b1;
            else      bus_read_response_i  = 1'b1;
         end else begin
            if (!mute) m_lat--;
            if ($urandom_range(0, 2) == 0) begin
               if (m_wr) bus_read_response_i  = 1'b1;
               else      bus_write_response_i = 1'b1;
            end
`ifdef BUS_ARBITER_TIMEOUT_EN
            if (m_cnt == TO) begin
               fire = 1'b1;
               tmo  = 1'b1;
            end
`endif
         end
      end else begin
         bus_read_response_i  = 1'($urandom_range(0, 1));
         bus_write_response_i = 1'($urandom_range(0, 1));
      end
      #1;
      chk("grant", 32'(grant_o), m_busy ? 32'(1 << m_owner) : 32'h0);
      chk("bus_read_request", 32'(bus_read_request_o), 32'(m_busy && !m_wr));
      chk("bus_write_request", 32'(bus_write_request_o), 32'(m_busy && m_wr));
      if (m_busy) begin
         chk("bus_address", bus_rw_address_o, m_addr);
         if (m_wr) begin
            chk("bus_write_data", bus_write_data_o, m_data);
            chk("bus_write_strobe", 32'(bus_write_strobe_o), 32'(m_strb));
         end
      end
      for (int h = 0; h < N; h++) begin
         chk("host_read_response", 32'(host_read_response_o[h]),
             32'(fire && !m_wr && h == m_owner));
         chk("host_write_response", 32'(host_write_response_o[h]),
             32'(fire && m_wr && h == m_owner));
         if (!m_busy || h != m_owner)
            chk("idle_read_data", host_read_data_o[32*h +: 32], 32'h0);
         else if (fire && !m_wr)
            chk("read_data", host_read_data_o[32*h +: 32], tmo ? 32'h0 : bus_read_data_i);
         if (host_read_response_o[h] || host_write_response_o[h]) got_q.push_back(32'(h));
      end
      done_host = -1;
      if (m_busy) begin
         if (fire) begin
            m_busy    = 1'b0;
            m_rr      = m_owner;
            done_host = m_owner;
         end else begin
            m_cnt++;
         end
      end else begin
         req   = host_read_request_i | host_write_request_i;
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            if (!found && req[(m_rr + k) % N]) begin
               found   = 1'b1;
               m_owner = (m_rr + k) % N;
            end
         end
         if (found) begin
            m_busy = 1'b1;
            m_wr   = host_write_request_i[m_owner];
            m_addr = host_rw_address_i[32*m_owner +: 32];
            m_data = host_write_data_i[32*m_owner +: 32];
            m_strb = host_write_strobe_i[4*m_owner +: 4];
            m_cnt  = 0;
            m_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
         end
      end
      @(posedge clock);
      #1;
      for (int h = 0; h < N; h++) just_done[h] = 1'b0;
      if (done_host >= 0) begin
         host_read_request_i[done_host]  = 1'b0;
         host_write_request_i[done_host] = 1'b0;
         just_done[done_host] = 1'b1;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      host_read_request_i  = '0;
      host_write_request_i = '0;
      bus_read_response_i  = 1'b1;
      bus_write_response_i = 1'b1;
      #1;
      chk("reset_grant", 32'(grant_o), 32'h0);
      chk("reset_bus_read_request", 32'(bus_read_request_o), 32'h0);
      chk("reset_bus_write_request", 32'(bus_write_request_o), 32'h0);
      chk("reset_bus_address", bus_rw_address_o, 32'h0);
      chk("reset_host_read_response", 32'(host_read_response_o), 32'h0);
      chk("reset_host_write_response", 32'(host_write_response_o), 32'h0);
      for (int h = 0; h < N; h++)
         chk("reset_host_read_data", host_read_data_o[32*h +: 32], 32'h0);
      m_busy = 1'b0;
      m_rr   = N - 1;
      for (int h = 0; h < N; h++) just_done[h] = 1'b0;
      bus_read_response_i  = 1'b0;
      bus_write_response_i = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic refill(input int pct);
      int t;
      for (int h = 0; h < N; h++) begin
         if (!host_read_request_i[h] && !host_write_request_i[h] && !just_done[h] &&
             $urandom_range(0, 99) < pct) begin
            t = int'($urandom_range(0, 3));   // 0 read, 1-2 write, 3 read+write
            set_host(h, t == 0 || t == 3, t != 0, $urandom, $urandom, 4'($urandom_range(1, 15)));
         end
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 100 && any_req(); c++) tick();
      chk("drain_done", 32'(any_req()), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Host0 read, memory answers on the first BUSY cycle with a known word.
      fixed_lat = 0;
      fixed_rdata_en = 1'b1;
      fixed_rdata = 32'hCAFE_F00D;
      got_q.delete();
      set_host(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
      tick();
      chk("t1_bus_read_request", 32'(bus_read_request_o), 32'h1);
      chk("t1_bus_address", bus_rw_address_o, 32'h0000_0010);
      tick();
      tick();
      chk("t1_response_count", 32'(got_q.size()), 32'h1);
      chk("t1_response_host", got_q[0], 32'h0);
      fixed_rdata_en = 1'b0;
      fixed_lat = -1;

      // Both hosts requesting continuously from reset: strict alternation starting at host0.
      do_reset();
      got_q.delete();
      for (int c = 0; c < 200 && got_q.size() < 6; c++) begin
         refill(100);
         tick();
      end
      drain();
      chk("t3_count", 32'(got_q.size() >= 6), 32'h1);
      for (int i = 0; i < 6; i++) chk("t3_order", got_q[i], 32'(i % 2));

      // Host1 write with fixed fields.
      got_q.delete();
      fixed_lat = 1;
      set_host(1, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0041, 4'b0001);
      tick();
      chk("t4_bus_write_request", 32'(bus_write_request_o), 32'h1);
      chk("t4_bus_address", bus_rw_address_o, 32'h8000_0000);
      chk("t4_bus_write_data", bus_write_data_o, 32'h0000_0041);
      chk("t4_bus_write_strobe", 32'(bus_write_strobe_o), 32'h1);
      chk("t4_grant", 32'(grant_o), 32'h2);
      drain();
      chk("t4_response_host", got_q[0], 32'h1);
      fixed_lat = -1;

      // Reset while BUSY abandons the transaction; arbitration restarts at host0.
      mute = 1'b1;
      set_host(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
      tick();
      tick();
      do_reset();
      mute = 1'b0;
      set_host(0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
      set_host(1, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
      tick();
      chk("t5_grant_after_reset", 32'(grant_o), 32'h1);
      drain();

      // Unmapped read with a silent memory.
      got_q.delete();
      mute = 1'b1;
      set_host(0, 1'b1, 1'b0, 32'hDEAD_0000, 32'h0, 4'h0);
      base = 0;
      for (int c = 0; c < 110; c++) begin
         tick();
         if (got_q.size() == 0) base++;
      end
`ifdef BUS_ARBITER_TIMEOUT_EN
      chk("t6_timeout_host", got_q[0], 32'h0);
      chk("t6_timeout_cycles", 32'(base), 32'(TO + 1));
`else
      chk("t6_no_response", 32'(got_q.size()), 32'h0);
      chk("t6_request_held", 32'(bus_read_request_o), 32'h1);
`endif
      mute = 1'b0;
      drain();

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 300; c++) begin
         refill(50);
         tick();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
